pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 102 ++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with legacy stall-vector mode or valid/ready skid-buffer mode
module pipe_stage_reg #(
    parameter int DATA_W    = 160,
    parameter int PC_W      = 32,
    parameter int MODE      = 0,
    parameter int STAGE_IDX = 2,
    parameter int STALL_W   = 6,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [PC_W-1:0]    in_pc,
    output logic               in_ready,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [PC_W-1:0]    out_pc,
    output logic [CNT_W-1:0]   bubble_cnt
);
    localparam int NEXT_IDX = STAGE_IDX + 1;
    logic              skid_valid, rdy;
    logic [DATA_W-1:0] skid_data;
    logic [PC_W-1:0]   skid_pc;
    logic              n_valid, n_skid_valid;
    logic [DATA_W-1:0] n_data, n_skid_data;
    logic [PC_W-1:0]   n_pc, n_skid_pc;
    logic              in_xfer, out_xfer;

    assign in_xfer  = in_valid && rdy;
    assign out_xfer = out_valid && out_ready;
    assign in_ready = (MODE == 0) ? !stall[STAGE_IDX] : rdy;

    // next state of main and skid registers; flush beats stall/handshake
    always_comb begin
        n_valid      = out_valid;
        n_data       = out_data;
        n_pc         = out_pc;
        n_skid_valid = skid_valid;
        n_skid_data  = skid_data;
        n_skid_pc    = skid_pc;
        if (flush) begin
            n_valid      = 1'b0;
            n_data       = '0;
            n_pc         = '0;
            n_skid_valid = 1'b0;
            n_skid_data  = '0;
            n_skid_pc    = '0;
        end else if (MODE == 0) begin
            if (!stall[STAGE_IDX]) begin
                n_valid = in_valid;
                n_data  = in_data;
                n_pc    = in_pc;
            end else if (!stall[NEXT_IDX]) begin
                n_valid = 1'b0;
                n_data  = '0;
                n_pc    = '0;
            end
        end else if (!out_valid || out_xfer) begin
            if (skid_valid) begin
                n_valid      = 1'b1;
                n_data       = skid_data;
                n_pc         = skid_pc;
                n_skid_valid = 1'b0;
            end else begin
                n_valid = in_xfer;
                n_data  = in_xfer ? in_data : '0;
                n_pc    = in_xfer ? in_pc : '0;
            end
        end else if (in_xfer) begin
            n_skid_valid = 1'b1;
            n_skid_data  = in_data;
            n_skid_pc    = in_pc;
        end
    end

    // register all state; bubble counter saturates on post-edge invalid cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_pc     <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_pc    <= '0;
            rdy        <= 1'b1;
            bubble_cnt <= '0;
        end else begin
            out_valid  <= n_valid;
            out_data   <= n_data;
            out_pc     <= n_pc;
            skid_valid <= n_skid_valid;
            skid_data  <= n_skid_data;
            skid_pc    <= n_skid_pc;
            rdy        <= !n_skid_valid;
            bubble_cnt <= (!n_valid && bubble_cnt != '1) ? bubble_cnt + 1'b1 : bubble_cnt;
        end
    end
endmodule
